// File: rtl/axis_out_framer.sv
// axis_out_framer: frames an upstream pixel stream into one output image of
// DST_IMG_WIDTH x DST_IMG_HEIGHT pixels, regenerating tlast/tuser.
// Latency: 1 cycle from upstream accept to m_axis_tvalid (2-entry skid buffer).
// Backpressure: s_axis_tready is registered "buffer not full"; there is no
// combinational path from m_axis_tready.
// Ports: clk/rst_n (async active-low); start pulse arms one frame;
// s_axis_* upstream stream (tlast is only checked); m_axis_* downstream stream;
// frame_done pulses once per frame; tlast_err is a sticky upstream tlast mismatch.
module axis_out_framer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DST_IMG_WIDTH  = 3840,
  parameter int DST_IMG_HEIGHT = 2160
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic                  tlast_err
);

  localparam int COL_W = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
  localparam int ROW_W = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DST_IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic                  frame_full_q, frame_full_d;  // every pixel of the frame accepted
  logic                  s_rdy_q, s_rdy_d;
  logic                  err_q;

  // Skid buffer: two entries, each carrying the pixel plus its sideband bits.
  // buf_eof marks the final pixel of the frame so the FSM can retire on its pop.
  logic [DATA_WIDTH-1:0] buf_dat [2];
  logic [1:0]            buf_last, buf_user, buf_eof;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            cnt_q, cnt_d;

  logic push, pop, col_last, row_last, start_go;

  assign push     = s_axis_tvalid & s_rdy_q;
  assign pop      = m_axis_tvalid & m_axis_tready;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign start_go = (state_q == IDLE) & start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (pop && buf_eof[rd_ptr]) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    frame_full_d = frame_full_q;
    if (start_go)
      frame_full_d = 1'b0;
    else if (push && col_last && row_last)
      frame_full_d = 1'b1;
    // Ready for the next cycle is decided from next-cycle state only, so it
    // can be a plain flop.
    s_rdy_d = (state_d == RUN) && !frame_full_d && (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      frame_full_q <= 1'b0;
      s_rdy_q      <= 1'b0;
      err_q        <= 1'b0;
      buf_dat[0]   <= '0;
      buf_dat[1]   <= '0;
      buf_last     <= '0;
      buf_user     <= '0;
      buf_eof      <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      frame_full_q <= frame_full_d;
      s_rdy_q      <= s_rdy_d;
      cnt_q        <= cnt_d;

      if (start_go) begin
        col_q <= '0;
        row_q <= '0;
      end else if (push) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      // Sideband is decided at accept time; upstream tlast only feeds the error flag.
      if (push) begin
        buf_dat[wr_ptr]  <= s_axis_tdata;
        buf_last[wr_ptr] <= col_last;
        buf_user[wr_ptr] <= (col_q == '0) && (row_q == '0);
        buf_eof[wr_ptr]  <= col_last && row_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;

      // A mismatch set takes priority over the clear from start.
      if (push && (s_axis_tlast != col_last))
        err_q <= 1'b1;
      else if (start_go)
        err_q <= 1'b0;
    end
  end

  assign s_axis_tready = s_rdy_q;
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = buf_dat[rd_ptr];
  assign m_axis_tlast  = buf_last[rd_ptr];
  assign m_axis_tuser  = buf_user[rd_ptr];
  assign frame_done    = (state_q == DONE);
  assign tlast_err     = err_q;

endmodule
